// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: FSM state encoding, default M-extension wait limit, the pipeline
//          NOP encoding used by the stage-register flush logic, and the
//          redirect-target alignment helper.
// Ports:   none (package).
package pipeline_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } ctrl_state_e;

  localparam int MULDIV_TIMEOUT_DEFAULT = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Jump targets from JALR can carry bit 0 set; the fetch address never does.
  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/muldiv_wait_timer.sv
// rtl/muldiv_wait_timer.sv - bounded wait counter for multi-cycle M-extension operations
//
// Purpose: counts WAIT cycles and flags the cycle in which the wait limit is
//          reached; that flag doubles as the one-cycle timeout error pulse.
// Ports:
//   CLK      in   core clock
//   RESET    in   synchronous active-high reset
//   CLEAR    in   hold the counter at 0
//   ENABLE   in   a counting WAIT cycle (no result this cycle)
//   EXPIRED  out  this is the final allowed WAIT cycle; counter clears
module muldiv_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = MULDIV_TIMEOUT_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic CLEAR,
  input  logic ENABLE,
  output logic EXPIRED
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    EXPIRED = 1'b0;
    if (CLEAR) begin
      count_d = '0;
    end else if (ENABLE) begin
      // The limit is reached before the counter could ever wrap.
      if (count_q == LAST_COUNT) begin
        EXPIRED = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage RV32IM pipeline
//
// Purpose: priority decode of branch redirect, multi-cycle M-op wait and
//          load-use bubble; RUN/WAIT FSM with bounded M-op wait.
// Optional feature: BRANCH_STATS_EN adds TAKEN_COUNT / STALL_COUNT counters.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   BRANCH_SELECT, TARGET_ADDRESS  EX-stage taken flag and redirect target
//   LOAD_USE_HAZARD            ID reads rd of a load in EX
//   MULDIV_START, MULDIV_DONE  M-unit handshake
//   PC_WRITE_EN, PC_SEL, PC_TARGET  PC update controls
//   IF_ID_STALL, ID_EX_STALL   hold pipeline registers
//   IF_ID_FLUSH, ID_EX_FLUSH   load NOP into pipeline registers
//   EX_MEM_BUBBLE              inject NOP into EX/MEM
//   MULDIV_TIMEOUT_ERR         one-cycle pulse on M-op abort
//   BUSY                       FSM is in WAIT
//   TAKEN_COUNT, STALL_COUNT   statistics (BRANCH_STATS_EN only)
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_TIMEOUT = MULDIV_TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_SELECT,
  input  logic [31:0] TARGET_ADDRESS,
  input  logic        LOAD_USE_HAZARD,
  input  logic        MULDIV_START,
  input  logic        MULDIV_DONE,
  output logic        PC_WRITE_EN,
  output logic        PC_SEL,
  output logic [31:0] PC_TARGET,
  output logic        IF_ID_STALL,
  output logic        ID_EX_STALL,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_BUBBLE,
  output logic        MULDIV_TIMEOUT_ERR,
  output logic        BUSY
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] TAKEN_COUNT,
  output logic [31:0] STALL_COUNT
`endif
);

  ctrl_state_e state_q;
  ctrl_state_e state_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // The timer only runs on WAIT cycles without a result; everywhere else it
  // sits at 0 so a fresh M op always starts counting from zero.
  assign timer_enable = !RESET && (state_q == ST_WAIT) && !MULDIV_DONE;
  assign timer_clear  = !timer_enable;

  muldiv_wait_timer #(
    .TIMEOUT (MULDIV_TIMEOUT)
  ) u_wait_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLEAR   (timer_clear),
    .ENABLE  (timer_enable),
    .EXPIRED (timer_expired)
  );

  assign MULDIV_TIMEOUT_ERR = timer_expired;
  assign BUSY               = !RESET && (state_q == ST_WAIT);
  assign PC_TARGET          = PC_SEL ? align_target(TARGET_ADDRESS) : '0;

  always_comb begin
    state_d       = state_q;
    PC_WRITE_EN   = 1'b0;
    PC_SEL        = 1'b0;
    IF_ID_STALL   = 1'b0;
    ID_EX_STALL   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_RUN: begin
          if (BRANCH_SELECT) begin
            PC_WRITE_EN = 1'b1;
            PC_SEL      = 1'b1;
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (MULDIV_START && !MULDIV_DONE) begin
            state_d       = ST_WAIT;
            IF_ID_STALL   = 1'b1;
            ID_EX_STALL   = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
          end else if (MULDIV_START) begin
            // Single-cycle result: also masks a load-use hazard this cycle.
            PC_WRITE_EN = 1'b1;
          end else if (LOAD_USE_HAZARD) begin
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else begin
            PC_WRITE_EN = 1'b1;
          end
        end
        ST_WAIT: begin
          // EX holds the M op, so branch and load-use inputs are stale here.
          IF_ID_STALL   = 1'b1;
          ID_EX_STALL   = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          if (MULDIV_DONE || timer_expired) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count_q;
  logic [31:0] stall_count_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      taken_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if ((state_q == ST_RUN) && BRANCH_SELECT) begin
        taken_count_q <= taken_count_q + 32'd1;
      end
      if (!PC_WRITE_EN) begin
        stall_count_q <= stall_count_q + 32'd1;
      end
    end
  end

  assign TAKEN_COUNT = taken_count_q;
  assign STALL_COUNT = stall_count_q;
`endif

endmodule
